alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_stage_pkg.sv | 18 +
 rtl/reg_file8x16.sv | 36 +++
 rtl/alu_operand_stage.sv | 145 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU operand stage: default sizes, FSM states and op encodings.
package alu_stage_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/reg_file8x16.sv
// Register file: two operand read ports, one debug read port, one write port; R0 reads as zero.
module reg_file8x16 #(
  parameter int WIDTH = alu_stage_pkg::WIDTH,
  parameter int NREGS = alu_stage_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]         o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]         o_rdata_b,
  input  logic [$clog2(NREGS)-1:0] i_dbg_raddr,
  output logic [WIDTH-1:0]         o_dbg_rdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Index 0 is decoded to a constant so no write path can ever make R0 non-zero.
  assign o_rdata_a   = (i_raddr_a   == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b   == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_rdata = (i_dbg_raddr == '0) ? '0 : r_mem[i_dbg_raddr];

endmodule

// File: rtl/alu_operand_stage.sv
// Multi-cycle ALU operand stage: IDLE -> READ -> EXEC -> WB, feeding an external combinational ALU.
module alu_operand_stage #(
  parameter int WIDTH = alu_stage_pkg::WIDTH,
  parameter int NREGS = alu_stage_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [$clog2(NREGS)-1:0] rs,
  input  logic [$clog2(NREGS)-1:0] rt,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic                     ready,
  output logic [WIDTH-1:0]         alu_x,
  output logic [WIDTH-1:0]         alu_y,
  output logic                     alu_fsel,
  input  logic [WIDTH-1:0]         alu_z,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [WIDTH-1:0]         dbg_rdata
);

  import alu_stage_pkg::*;

  localparam int AW = $clog2(NREGS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_rs;
  logic [AW-1:0]    r_rt;
  logic [AW-1:0]    r_rd;
  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_aluout;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = READ;
        end
      end
      READ: w_state_nxt = EXEC;
      EXEC: w_state_nxt = WB;
      WB: begin
        // Gated by rst so an aborting reset in WB never shows a completion.
        done        = !rst;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Instruction latch (IDLE), operand fetch (READ) and result capture (EXEC).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_rs <= rs;
        r_rt <= rt;
        r_rd <= rd;
        r_op <= op_sub;
      end
      if (r_state == READ) begin
        r_a <= w_rdata_a;
        r_b <= w_rdata_b;
      end
      if (r_state == EXEC) begin
        r_aluout <= alu_z;
      end
    end
  end

  // External load and writeback share the single write port; they never overlap since
  // loads are only taken in IDLE and writeback only happens in WB.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst) begin
      if ((r_state == IDLE) && ld_en) begin
        w_we    = 1'b1;
        w_waddr = ld_addr;
        w_wdata = ld_data;
      end else if (r_state == WB) begin
        w_we    = 1'b1;
        w_waddr = r_rd;
        w_wdata = r_aluout;
      end
    end
  end

  reg_file8x16 #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_raddr_a   (r_rs),
    .o_rdata_a   (w_rdata_a),
    .i_raddr_b   (r_rt),
    .o_rdata_b   (w_rdata_b),
    .i_dbg_raddr (dbg_raddr),
    .o_dbg_rdata (dbg_rdata)
  );

  assign alu_x    = r_a;
  assign alu_y    = r_b;
  assign alu_fsel = r_op;
  assign result   = r_aluout;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural add/subtract ALU on alu_z.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ready;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_fsel;
  logic [15:0] alu_z;
  logic        done;
  logic [15:0] result;
  logic [2:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_z = alu_fsel ? (alu_x - alu_y) : (alu_x + alu_y);

  alu_operand_stage #(.WIDTH(16), .NREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ready     (ready),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_fsel  (alu_fsel),
    .alu_z     (alu_z),
    .done      (done),
    .result    (result),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    dbg_raddr = idx;
    #1;
    check_eq(tag, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic load_reg(input logic [2:0] addr, input logic [15:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Issues one op from IDLE and checks every cycle through the return to IDLE.
  task automatic run_op(input string tag, input logic sub, input logic [2:0] a_idx,
                        input logic [2:0] b_idx, input logic [2:0] d_idx,
                        input logic [15:0] x_exp, input logic [15:0] y_exp,
                        input logic [15:0] z_exp, input logic [15:0] rd_exp);
    check_eq({tag, "_ready_pre"}, 32'(ready), 32'd1);
    start  = 1'b1;
    op_sub = sub;
    rs     = a_idx;
    rt     = b_idx;
    rd     = d_idx;
    tick();
    start  = 1'b0;
    rs     = 3'd7;
    rt     = 3'd7;
    check_eq({tag, "_read_busy"}, {30'd0, ready, done}, 32'd0);
    tick();
    check_eq({tag, "_exec_x"}, 32'(alu_x), 32'(x_exp));
    check_eq({tag, "_exec_y"}, 32'(alu_y), 32'(y_exp));
    check_eq({tag, "_exec_fsel"}, 32'(alu_fsel), 32'(sub));
    check_eq({tag, "_exec_done"}, 32'(done), 32'd0);
    tick();
    check_eq({tag, "_wb_done"}, 32'(done), 32'd1);
    check_eq({tag, "_wb_result"}, 32'(result), 32'(z_exp));
    tick();
    check_eq({tag, "_post_done_ready"}, {30'd0, ready, done}, 32'd2);
    check_eq({tag, "_post_result"}, 32'(result), 32'(z_exp));
    check_reg({tag, "_rd"}, d_idx, rd_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; rs = '0; rt = '0; rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;

    // Reset with start/ld_en asserted: both must be ignored.
    start = 1'b1; ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h1111;
    tick();
    tick();
    start = 1'b0; ld_en = 1'b0;
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_alu_x", 32'(alu_x), 32'd0);
    check_reg("rst_r1", 3'd1, 16'h0000);
    tick();
    check_eq("rst_idle_hold", 32'(ready), 32'd1);

    load_reg(3'd1, 16'h0005);
    load_reg(3'd2, 16'h0003);
    check_reg("ld_r1", 3'd1, 16'h0005);
    check_reg("ld_r2", 3'd2, 16'h0003);

    run_op("add123", 1'b0, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0008, 16'h0008);
    run_op("sub124", 1'b1, 3'd1, 3'd2, 3'd4, 16'h0005, 16'h0003, 16'h0002, 16'h0002);
    run_op("sub215", 1'b1, 3'd2, 3'd1, 3'd5, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE);

    load_reg(3'd6, 16'hFFFF);
    load_reg(3'd7, 16'h0001);
    run_op("wrap", 1'b0, 3'd6, 3'd7, 3'd6, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000);
    run_op("after_wrap", 1'b0, 3'd6, 3'd1, 3'd7, 16'h0000, 16'h0005, 16'h0005, 16'h0005);

    run_op("r0_add", 1'b0, 3'd0, 3'd1, 3'd0, 16'h0000, 16'h0005, 16'h0005, 16'h0000);
    load_reg(3'd0, 16'h1234);
    check_reg("ld_r0", 3'd0, 16'h0000);

    // start held through READ/EXEC plus a load attempted in EXEC.
    start = 1'b1; op_sub = 1'b1; rs = 3'd1; rt = 3'd2; rd = 3'd3;
    tick();
    rs = 3'd6; op_sub = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'hAAAA;
    check_eq("hold_exec_fsel", 32'(alu_fsel), 32'd1);
    tick();
    start = 1'b0; ld_en = 1'b0;
    check_eq("hold_wb_done", 32'(done), 32'd1);
    check_eq("hold_wb_result", 32'(result), 32'h0002);
    tick();
    check_eq("hold_idle", {30'd0, ready, done}, 32'd2);
    tick();
    check_eq("hold_single_op", {30'd0, ready, done}, 32'd2);
    check_reg("hold_r2", 3'd2, 16'h0003);
    check_reg("hold_r3", 3'd3, 16'h0002);

    // Load and start in the same IDLE cycle: READ sees the new value.
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h0010;
    run_op("ld_start", 1'b0, 3'd5, 3'd1, 3'd4, 16'h0010, 16'h0005, 16'h0015, 16'h0015);
    ld_en = 1'b0;

    // Reset during EXEC aborts the op.
    start = 1'b1; op_sub = 1'b0; rs = 3'd1; rt = 3'd2; rd = 3'd3;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("abort_rst_done", 32'(done), 32'd0);
    check_eq("abort_rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    tick();
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_reg("abort_r3", 3'd3, 16'h0000);
    tick();
    check_eq("abort_no_late_done", {30'd0, ready, done}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
